// File: rtl/pat_code_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pat_code_encoder
// Purpose  : Turns signed paddle-velocity samples and clear/stall requests
//            into 16-bit paddle command words. The words are queued in a
//            2-entry FIFO and released to the consumer on each Fetch pulse.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   sample_valid  in   one-cycle strobe qualifying sample_vx / sample_vy
//   sample_vx     in   signed horizontal velocity (W bits, two's complement)
//   sample_vy     in   signed vertical velocity   (W bits, two's complement)
//   clear_req     in   one-cycle request to enqueue a Clear word
//   stall_req     in   one-cycle request to enqueue a Stall word
//   Fetch         in   consumer pop strobe
//   Code          out  head FIFO word, 16'h0000 while the FIFO is empty
//   code_valid    out  FIFO holds at least one word
//   drop_cnt      out  saturating count of discarded words and requests
// ----------------------------------------------------------------------------
// Word layout: [15]=1, [14]=direction_y (swing), [13]=direction_x (vx<0),
//              [12:11]=cmd (00 move, 01 clear, 10 stall), [10:0]=magnitude
// ============================================================================
module pat_code_encoder #(
  parameter int W          = 12,
  parameter int DEAD_ZONE  = 16,
  parameter int SWING_TH   = 512,
  parameter int SWING_HOLD = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] sample_vx,
  input  logic [W-1:0] sample_vy,
  input  logic         clear_req,
  input  logic         stall_req,
  input  logic         Fetch,
  output logic [15:0]  Code,
  output logic         code_valid,
  output logic [7:0]   drop_cnt
);

  localparam int          MAG_MAX   = 2047;
  localparam int          HOLD_W    = (SWING_HOLD > 1) ? $clog2(SWING_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((SWING_HOLD > 0) ? SWING_HOLD - 1 : 0);

  typedef enum logic [1:0] {
    CMD_MOVE  = 2'b00,
    CMD_CLEAR = 2'b01,
    CMD_STALL = 2'b10
  } cmd_t;

  // --------------------------------------------------------------------------
  // Input arbitration: clear beats stall beats sample. Every asserted input
  // that loses counts as one drop.
  // --------------------------------------------------------------------------
  logic       sel_valid;
  cmd_t       sel_cmd;
  logic [1:0] req_cnt;
  logic [1:0] arb_drops;

  always_comb begin
    req_cnt   = 2'(clear_req) + 2'(stall_req) + 2'(sample_valid);
    sel_valid = clear_req | stall_req | sample_valid;
    arb_drops = sel_valid ? (req_cnt - 2'd1) : 2'd0;
    if (clear_req)      sel_cmd = CMD_CLEAR;
    else if (stall_req) sel_cmd = CMD_STALL;
    else                sel_cmd = CMD_MOVE;
  end

  // --------------------------------------------------------------------------
  // Sample field encoding. Arithmetic is done in int so that the -2^(W-1)
  // corner has a representable magnitude before saturation.
  // --------------------------------------------------------------------------
  int          vx_i;
  int          vy_i;
  int          abs_vx;
  logic [10:0] smp_mag;
  logic        smp_neg;
  logic        smp_swing;

  always_comb begin
    vx_i      = int'($signed(sample_vx));
    vy_i      = int'($signed(sample_vy));
    abs_vx    = (vx_i < 0) ? -vx_i : vx_i;
    smp_neg   = (vx_i < 0);
    smp_swing = (vy_i >= SWING_TH);
    if (abs_vx < DEAD_ZONE)     smp_mag = 11'd0;
    else if (abs_vx > MAG_MAX)  smp_mag = 11'(MAG_MAX);
    else                        smp_mag = 11'(abs_vx);
  end

  // --------------------------------------------------------------------------
  // Stage 1 register. The swing candidate is kept raw and qualified with the
  // holdoff counter as the word is written, so a swing that lands in the FIFO
  // suppresses one sitting right behind it in this stage.
  // --------------------------------------------------------------------------
  logic        st_valid;
  cmd_t        st_cmd;
  logic        st_neg;
  logic        st_swing;
  logic [10:0] st_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid <= 1'b0;
      st_cmd   <= CMD_MOVE;
      st_neg   <= 1'b0;
      st_swing <= 1'b0;
      st_mag   <= 11'd0;
    end else begin
      st_valid <= sel_valid;
      st_cmd   <= sel_cmd;
      if (sel_cmd == CMD_MOVE) begin
        st_neg   <= smp_neg;
        st_swing <= smp_swing;
        st_mag   <= smp_mag;
      end else begin
        st_neg   <= 1'b0;
        st_swing <= 1'b0;
        st_mag   <= 11'd0;
      end
    end
  end

  logic [HOLD_W-1:0] hold_cnt;
  logic              st_dy;
  logic [15:0]       st_word;

  always_comb begin
    st_dy   = st_swing && (hold_cnt == '0);
    st_word = {1'b1, st_dy, st_neg, st_cmd, st_mag};
  end

  // --------------------------------------------------------------------------
  // 2-entry FIFO (head/tail). A write into a full FIFO survives only if the
  // consumer pops in the same cycle.
  // --------------------------------------------------------------------------
  logic [15:0] head;
  logic [15:0] tail;
  logic [1:0]  fifo_cnt;
  logic        pop;
  logic        wr_drop;
  logic        wr_accept;

  always_comb begin
    pop       = Fetch && (fifo_cnt != 2'd0);
    wr_drop   = st_valid && (fifo_cnt == 2'd2) && !pop;
    wr_accept = st_valid && !wr_drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= 16'h0000;
      tail     <= 16'h0000;
      fifo_cnt <= 2'd0;
    end else begin
      case (fifo_cnt)
        2'd0: begin
          if (st_valid) begin
            head     <= st_word;
            fifo_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && st_valid) begin
            head <= st_word;                 // occupancy stays at 1
          end else if (pop) begin
            fifo_cnt <= 2'd0;
          end else if (st_valid) begin
            tail     <= st_word;
            fifo_cnt <= 2'd2;
          end
        end
        default: begin
          if (pop && st_valid) begin
            head <= tail;
            tail <= st_word;                 // stays full
          end else if (pop) begin
            head     <= tail;
            fifo_cnt <= 2'd1;
          end
          // write without pop is dropped; contents unchanged
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Swing holdoff: armed only by a swing word that actually enters the FIFO.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (wr_accept && st_dy) begin
      hold_cnt <= HOLD_LOAD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Drop counter: up to three drops per cycle, clipped at 255.
  // --------------------------------------------------------------------------
  logic [9:0] drop_sum;

  always_comb begin
    drop_sum = 10'(drop_cnt) + 10'(arb_drops) + 10'(wr_drop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (drop_sum > 10'd255) begin
      drop_cnt <= 8'hFF;
    end else begin
      drop_cnt <= drop_sum[7:0];
    end
  end

  // Outputs are a direct view of FIFO state, so reset clears them at once.
  always_comb begin
    code_valid = (fifo_cnt != 2'd0);
    Code       = code_valid ? head : 16'h0000;
  end

endmodule
`default_nettype wire

// File: doc/pat_code_encoder.md
# pat_code_encoder

Produces the 16-bit paddle command word `Code` consumed by the paddle datapath's code decoder. It converts signed paddle-velocity samples and clear/stall requests into encoded words. Words are queued in a 2-entry FIFO and each is released when the consumer pulses `Fetch`. It sits between the motion-sample front end and the paddle datapath, and it is the producing end of the `Code`/`Fetch` interface.

## Interface
- `W`, 12: width of signed velocity samples (two's complement).
- `DEAD_ZONE`, 16: if |vx| is below this value, the magnitude field is encoded as 0.
- `SWING_TH`, 512: if vy ≥ this value, the word is a swing (direction_y=1).
- `SWING_HOLD`, 1000: number of cycles after an accepted swing word during which further swings are suppressed.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sample_valid` in 1: one-cycle strobe; `sample_vx` and `sample_vy` are valid in that cycle.
- `sample_vx` in W: signed horizontal velocity.
- `sample_vy` in W: signed vertical velocity.
- `clear_req` in 1: one-cycle request to enqueue a Clear word.
- `stall_req` in 1: one-cycle request to enqueue a Stall word.
- `Fetch` in 1: consumer pop strobe.
- `Code` out 16: head FIFO word; 16'h0000 when the FIFO is empty.
- `code_valid` out 1: FIFO is non-empty.
- `drop_cnt` out 8: saturating count of discarded words and requests.

## Operation
- Word format:
  - [15]=1 for every emitted word.
  - [14]=direction_y (swing).
  - [13]=direction_x (1 means vx<0).
  - [12:11]=cmd: 00 move, 01 clear, 10 stall, 11 reserved and never emitted.
  - [10:0]=magnitude.
- Move word:
  - mag = |vx|, saturated to 2047; vx = −2048 gives 2047.
  - mag is forced to 0 if |vx| < DEAD_ZONE. direction_x still follows the sign of vx.
  - direction_y = (vy ≥ SWING_TH) AND (holdoff counter == 0).
- Clear word: 16'h8800. Stall word: 16'h9000. Both have direction and magnitude fields 0.
- Input arbitration per cycle, in priority order: clear_req, then stall_req, then sample_valid.
  - The winner enters the encode stage register.
  - Every losing asserted input increments drop_cnt.
- Pipeline: stage 1 registers the selected request and encodes it. At the next edge, the encoded word is written to the FIFO.
- FIFO: 2 entries, holding head and tail.
  - Pop occurs when `Fetch && code_valid`. `Fetch` while empty is ignored and has no side effects.
  - Write when full with no pop: the word is discarded and drop_cnt increments.
  - Write when full with a simultaneous pop: the pop is performed and the write is accepted, leaving the FIFO full.
  - Write and pop on a 1-entry FIFO: the FIFO ends holding 1 entry, the new word.
- Swing holdoff:
  - The counter loads SWING_HOLD−1 when a word with [14]=1 is actually written into the FIFO. Dropped words do not load it.
  - It decrements to 0 and holds there.
  - While it is nonzero, vy is ignored for direction_y. The rest of the word is encoded normally.
- drop_cnt saturates at 255 and never wraps. When multiple drops occur in one cycle, it increments by the number of drops, clipped at 255.

## Timing
- Reset, asynchronous and immediate, including mid-operation:
  - Code=16'h0000, code_valid=0, drop_cnt=0.
  - FIFO empty, stage 1 empty, holdoff counter=0.
- Latency from a request at edge E0 to code_valid/Code, with the FIFO initially empty: visible after E1, i.e. 2 edges.
- Pop: with `Fetch` sampled high at edge E, Code shows the next entry, or 0, after E.
- Back-to-back samples on consecutive cycles are accepted at full rate. The FIFO absorbs at most 2 unfetched words.
- Ordering is strictly first in, first out across move, clear and stall words.

## Test plan
- Reset, then sample vx=−300, vy=600 → after 2 edges: code_valid=1, Code=16'hE12C. Holdoff then starts at 999.
- Within the holdoff window, sample vx=−300, vy=600 → Code=16'hA12C; that word has no swing.
- Sample vx=10, vy=0 → 16'h8000. Sample vx=−2048, vy=0 → 16'hA7FF, showing saturation.
- Three samples with no `Fetch` → FIFO keeps the first two, and drop_cnt=1. Then `Fetch` twice → Code steps to the second word, then code_valid=0 and Code=0.
- clear_req, stall_req and sample_valid asserted together → only 16'h8800 is queued, and drop_cnt increases by 2.
- Assert `rst` while the FIFO is full and holdoff is active → all outputs return to 0 at once. The next swing sample encodes [14]=1.
